// File: rtl/rv_pkg.sv
// Shared encodings for the writeback stage: result-source selects, load funct3 codes
// and the layout of the WB pipeline register.
package rv_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC   = 2'd2;
    localparam logic [1:0] WB_SEL_RSV  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] pc_plus4;
    } wb_reg_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from an aligned data word and flags
// accesses whose offset does not match the access size.
module load_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] value,
    output logic        misalign
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select lane, then extend according to the load type
    always_comb begin
        byte_val = 8'(word >> {offset, 3'b000});
        half_val = 16'(word >> {offset[1], 4'b0000});
        value    = 32'h0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  value = {{24{byte_val[7]}}, byte_val};
            F3_LH: begin
                value    = {{16{half_val[15]}}, half_val};
                misalign = offset[0];
            end
            F3_LW: begin
                value    = word;
                misalign = (offset != 2'b00);
            end
            F3_LBU: value = {24'h0, byte_val};
            F3_LHU: begin
                value    = {16'h0, half_val};
                misalign = offset[0];
            end
            default: value = 32'h0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds the MEM/WB pipeline register, selects the result,
// drives the register-file write port and counts retired instructions.
module wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_load_data,
    input  logic [31:0]      mem_pc_plus4,
    output logic             write_en,
    output logic [4:0]       write_addr,
    output logic [31:0]      write_data,
    output logic             load_misalign,
    output logic [CNT_W-1:0] retired_cnt
);

    wb_reg_t          wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [31:0]      load_value;
    logic             load_mis_raw;

    load_align u_load_align (
        .funct3   (wb_q.funct3),
        .offset   (wb_q.alu_result[1:0]),
        .word     (wb_q.load_data),
        .value    (load_value),
        .misalign (load_mis_raw)
    );

    // Next WB register: flush beats stall, stall holds, otherwise capture MEM
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d = '0;
        end else if (!stall) begin
            wb_d.valid      = mem_valid;
            wb_d.reg_write  = mem_reg_write;
            wb_d.rd         = mem_rd_addr;
            wb_d.wb_sel     = mem_wb_sel;
            wb_d.funct3     = mem_funct3;
            wb_d.alu_result = mem_alu_result;
            wb_d.load_data  = mem_load_data;
            wb_d.pc_plus4   = mem_pc_plus4;
        end
    end

    // Retire counter advances on every retiring instruction, write or not
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs depend only on WB register contents and stall
    always_comb begin
        retire        = wb_q.valid & ~stall;
        load_misalign = wb_q.valid & (wb_q.wb_sel == WB_SEL_LOAD) & load_mis_raw;
        write_addr    = wb_q.rd;
        write_data    = 32'h0;
        case (wb_q.wb_sel)
            WB_SEL_ALU:  write_data = wb_q.alu_result;
            WB_SEL_LOAD: write_data = load_value;
            WB_SEL_PC:   write_data = wb_q.pc_plus4;
            WB_SEL_RSV:  write_data = 32'h0;
        endcase
        write_en = retire & wb_q.reg_write & (wb_q.rd != 5'd0) & ~load_misalign
                   & (wb_q.wb_sel != WB_SEL_RSV);
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic, all checked
// against an instruction-level model of the writeback stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, mem_valid, mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;

    logic        write_en, load_misalign;
    logic [4:0]  write_addr;
    logic [31:0] write_data, retired_cnt;
    logic        write_en4, load_misalign4;
    logic [4:0]  write_addr4;
    logic [31:0] write_data4;
    logic [3:0]  retired_cnt4;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .load_misalign(load_misalign), .retired_cnt(retired_cnt)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .write_en(write_en4), .write_addr(write_addr4), .write_data(write_data4),
        .load_misalign(load_misalign4), .retired_cnt(retired_cnt4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: the instruction sitting in WB, and the number retired so far
    bit              m_valid, m_rw;
    int unsigned     m_rd, m_sel, m_f3;
    bit [31:0]       m_alu, m_ld, m_pc;
    longint unsigned m_cnt;

    function automatic bit [31:0] ref_load(int unsigned f3, int unsigned off, bit [31:0] w);
        bit [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            2: return w;
            4: return b;
            5: return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_misal();
        int unsigned off;
        off = m_alu % 4;
        if (!m_valid || m_sel != 1) return 1'b0;
        if ((m_f3 == 1 || m_f3 == 5) && (off % 2 == 1)) return 1'b1;
        if (m_f3 == 2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
        m_alu = 0; m_ld = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        if (m_valid && !stall) m_cnt++;
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd_addr;
            m_sel = mem_wb_sel; m_f3 = mem_funct3; m_alu = mem_alu_result;
            m_ld = mem_load_data; m_pc = mem_pc_plus4;
        end
    endtask

    task automatic check_all();
        bit        mis, we;
        bit [31:0] data;
        mis = ref_misal();
        we  = m_valid && !stall && m_rw && m_rd != 0 && !mis && m_sel != 3;
        case (m_sel)
            0: data = m_alu;
            1: data = ref_load(m_f3, m_alu % 4, m_ld);
            2: data = m_pc;
            default: data = 32'h0;
        endcase
        check("write_en", {31'b0, write_en}, {31'b0, we});
        check("load_misalign", {31'b0, load_misalign}, {31'b0, mis});
        if (m_valid) begin
            check("write_addr", {27'b0, write_addr}, m_rd);
            check("write_data", write_data, data);
        end
        check("retired_cnt", retired_cnt, 32'(m_cnt));
        check("retired_cnt4", {28'b0, retired_cnt4}, 32'(m_cnt % 16));
        check("write_en4", {31'b0, write_en4}, {31'b0, we});
    endtask

    // One clock: apply inputs, check at negedge, advance model at posedge
    task automatic cycle(input bit st, input bit fl, input bit v, input bit rw,
                         input bit [4:0] rd, input bit [1:0] sel, input bit [2:0] f3,
                         input bit [31:0] alu, input bit [31:0] ld, input bit [31:0] pc);
        stall = st; flush = fl; mem_valid = v; mem_reg_write = rw; mem_rd_addr = rd;
        mem_wb_sel = sel; mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld;
        mem_pc_plus4 = pc;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic bubble();
        cycle(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".write_en"}, {31'b0, write_en}, 32'h0);
        check({tag, ".write_addr"}, {27'b0, write_addr}, 32'h0);
        check({tag, ".write_data"}, write_data, 32'h0);
        check({tag, ".load_misalign"}, {31'b0, load_misalign}, 32'h0);
        check({tag, ".retired_cnt"}, retired_cnt, 32'h0);
    endtask

    task automatic do_reset();
        stall = 0; flush = 0; mem_valid = 0; mem_reg_write = 0; mem_rd_addr = 0;
        mem_wb_sel = 0; mem_funct3 = 0; mem_alu_result = 0; mem_load_data = 0;
        mem_pc_plus4 = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        check_zero_outputs("after_reset");
    endtask

    initial begin
        bit [31:0] cnt0;
        rst_n = 1'b0;
        #12;
        do_reset();

        // ALU write to x5
        cycle(0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
        check("alu.we", {31'b0, write_en}, 32'h1);
        check("alu.addr", {27'b0, write_addr}, 32'd5);
        check("alu.data", write_data, 32'h1234_5678);
        bubble();
        check("alu.cnt", retired_cnt, 32'd1);

        // LB off 3, then LHU off 2, same word
        cycle(0, 0, 1, 1, 5'd7, 2'd1, 3'b000, 32'h0000_0003, 32'h80FF_0000, 32'h0);
        check("lb.data", write_data, 32'hFFFF_FF80);
        cycle(0, 0, 1, 1, 5'd8, 2'd1, 3'b101, 32'h0000_0002, 32'h80FF_0000, 32'h0);
        check("lhu.data", write_data, 32'h0000_80FF);
        bubble();

        // Misaligned LH still retires but does not write
        cnt0 = retired_cnt;
        cycle(0, 0, 1, 1, 5'd9, 2'd1, 3'b001, 32'h0000_0001, 32'h1111_2222, 32'h0);
        check("lh_mis.misalign", {31'b0, load_misalign}, 32'h1);
        check("lh_mis.we", {31'b0, write_en}, 32'h0);
        bubble();
        check("lh_mis.cnt", retired_cnt, cnt0 + 32'd1);

        // rd = 0 write is dropped but counted
        cnt0 = retired_cnt;
        cycle(0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        check("rd0.we", {31'b0, write_en}, 32'h0);
        bubble();
        check("rd0.cnt", retired_cnt, cnt0 + 32'd1);

        // Held for three stalled cycles, then a single write and count
        cnt0 = retired_cnt;
        cycle(0, 0, 1, 1, 5'd12, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_1004);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
            check("stall.cnt_hold", retired_cnt, cnt0);
        end
        bubble();
        check("stall.cnt_once", retired_cnt, cnt0 + 32'd1);
        bubble();
        check("stall.cnt_after", retired_cnt, cnt0 + 32'd1);

        // Stall together with flush: instruction becomes a bubble
        cnt0 = retired_cnt;
        cycle(0, 0, 1, 1, 5'd13, 2'd0, 3'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        cycle(1, 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        check("flush.we", {31'b0, write_en}, 32'h0);
        bubble();
        bubble();
        check("flush.cnt", retired_cnt, cnt0);

        // Sixteen retirements from reset wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 1, 5'(i), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
        end
        bubble();
        check("wrap.cnt4", {28'b0, retired_cnt4}, 32'h0);
        check("wrap.cnt32", retired_cnt, 32'd16);

        // Reset pulse while an instruction is held by stall
        cycle(0, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0);
        cycle(1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("midstall_rst");
        check("midstall_rst.cnt4", {28'b0, retired_cnt4}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        model_update();
        #1;
        bubble();
        check("midstall_rst.cnt_after", retired_cnt, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, rd,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom);
        end
        bubble();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  pipeline hold; WB register keeps its contents, nothing retires.
REQ-005 flush  in  1  replace WB register contents with a bubble at next edge.
REQ-006 mem_valid  in  1  MEM stage presents a real instruction.
REQ-007 mem_reg_write  in  1  instruction writes rd.
REQ-008 mem_rd_addr  in  5  destination register index.
REQ-009 mem_wb_sel  in  2  result source: 0 ALU, 1 load, 2 PC+4, 3 reserved.
REQ-010 mem_funct3  in  3  load width/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101).
REQ-011 mem_alu_result  in  32  ALU result; bits [1:0] are the load byte offset.
REQ-012 mem_load_data  in  32  raw aligned data word from data memory.
REQ-013 mem_pc_plus4  in  32  link value for JAL/JALR.
REQ-014 write_en  out  1  register-file write strobe.
REQ-015 write_addr  out  5  register-file write index.
REQ-016 write_data  out  32  register-file write data.
REQ-017 load_misalign  out  1  held load is misaligned; write suppressed.
REQ-018 retired_cnt  out  CNT_W  count of retired instructions.

Function
REQ-019 WB register (valid, reg_write, rd, wb_sel, funct3, alu_result, load_data, pc_plus4) SHALL load MEM inputs at each edge with stall=0 and flush=0.
REQ-020 flush SHALL take priority over stall: register valid cleared to 0 at next edge regardless of stall.
REQ-021 stall=1, flush=0 SHALL hold all WB register fields unchanged.
REQ-022 retire SHALL be defined combinationally as valid & !stall.
REQ-023 write_en SHALL equal retire & reg_write & (rd != 0) & !load_misalign.
REQ-024 write_addr and write_data SHALL be driven from the WB register every cycle, independent of write_en.
REQ-025 wb_sel 0 -> alu_result; 1 -> aligned load value; 2 -> pc_plus4; 3 -> 32'h0 with write_en forced 0.
REQ-026 Load extraction: byte = load_data[8*off +: 8], half = load_data[16*off[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; other funct3 -> 0.
REQ-027 load_misalign SHALL be 1 when valid & wb_sel==1 & ((half access & off[0]) | (LW & off!=0)); else 0.
REQ-028 Latency: MEM inputs captured at edge N drive write_en at cycle N+1; register file commits at edge N+1.
REQ-029 retired_cnt SHALL increment by 1 at each edge where retire=1 (misaligned and rd=0 instructions included), wrapping from all-ones to 0.
REQ-030 Outputs SHALL be combinational from WB register state plus stall only; no MEM-input-to-output paths.

Reset
REQ-031 rst_n low SHALL immediately clear valid, reg_write, all data fields and retired_cnt to 0.
REQ-032 During and after reset until the first capture: write_en=0, write_addr=0, write_data=0, load_misalign=0.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction; it never retires.

Structure
REQ-034 Shared package rv_pkg SHALL hold WB_SEL_ALU/LOAD/PC/RSV constants and the five load funct3 encodings.
REQ-035 Load extraction and misalignment check SHALL be a combinational sub-module load_align (inputs funct3, offset, word; outputs value, misalign).

Verification
REQ-036 ALU write: mem_valid=1, reg_write=1, rd=5, wb_sel=0, alu=0x1234_5678 -> next cycle write_en=1, addr=5, data=0x1234_5678, retired_cnt=1.
REQ-037 LB, off=3, word=0x80FF_0000 -> data=0xFFFF_FF80; LHU, off=2, same word -> data=0x0000_80FF.
REQ-038 LH, off=1 -> load_misalign=1, write_en=0, retired_cnt still increments.
REQ-039 rd=0 ALU write of 0xDEAD_BEEF -> write_en=0, retired_cnt increments.
REQ-040 Instruction held 3 cycles with stall=1 -> write_en=0 throughout, single write and single count after stall drops; stall=1 with flush=1 -> bubble, no write.
REQ-041 CNT_W=4, 16 retirements from reset -> retired_cnt wraps to 0; rst_n pulse mid-stall -> all outputs 0 within same cycle, no write.
